// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit: the instruction-memory request/response
// channel plus the decode-side delivery handshake.
interface instruction_fetch_unit_if #(
    parameter int PC_WIDTH   = 64,
    parameter int INST_WIDTH = 32
);
    // A transfer happens on a rising edge where valid and ready are both 1; valid never
    // depends on ready. imem_rsp_valid is a one-cycle pulse and has no ready.
    logic                  imem_req_valid;
    logic [PC_WIDTH-1:0]   imem_req_addr;
    logic                  imem_req_ready;
    logic                  imem_rsp_valid;
    logic [INST_WIDTH-1:0] imem_rsp_data;
    logic                  if_valid;
    logic [INST_WIDTH-1:0] if_inst;
    logic [PC_WIDTH-1:0]   if_pc;
    logic                  if_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_inst, if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_inst, if_pc,
        output if_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetch into a small FIFO feeding decode.
// Optional macro FETCH_MISALIGN_TRAP_EN traps misaligned redirects into a sticky HALT.
module instruction_fetch_unit #(
    parameter int PC_WIDTH   = 64,
    parameter int INST_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                CLK,
    input  logic                resetl,
    input  logic [PC_WIDTH-1:0] startPC,
    input  logic [PC_WIDTH-1:0] NextPC,
    input  logic                redirect,
    output logic [PC_WIDTH-1:0] CurrentPC,
    output logic                misalign,
    output logic [2:0]          state_dbg,
    instruction_fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_DRAIN = 3'd2,
        S_FULL  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t                state, state_next;
    logic [PC_WIDTH-1:0]   fetch_pc, target_pc, head_pc;
    logic [INST_WIDTH-1:0] head_inst;
    logic                  bad_target, head_valid;
    logic                  push, pop, flush, load_pc;
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count, count_after_push;
    logic [INST_WIDTH-1:0] buf_inst [BUF_DEPTH];
    logic [PC_WIDTH-1:0]   buf_pc   [BUF_DEPTH];

`ifdef FETCH_MISALIGN_TRAP_EN
    assign bad_target = (NextPC[1:0] != 2'b00);
    assign target_pc  = NextPC;
    // HALT is only left through reset, so the flag is sticky by construction.
    assign misalign   = (state == S_HALT);
`else
    assign bad_target = 1'b0;
    assign target_pc  = NextPC & ~PC_WIDTH'(3);
    assign misalign   = 1'b0;
`endif

    assign head_valid       = (count != '0);
    assign pop              = head_valid && bus.if_ready;
    assign count_after_push = count + CNT_W'(1) - CNT_W'(pop);

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) state <= S_REQ;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        push       = 1'b0;
        flush      = 1'b0;
        load_pc    = 1'b0;
        if (redirect && state != S_HALT) begin
            flush = 1'b1;
            if (bad_target) begin
                state_next = S_HALT;
            end else begin
                load_pc = 1'b1;
                // A request already accepted must have its response swallowed in DRAIN.
                case (state)
                    S_REQ:   state_next = bus.imem_req_ready ? S_DRAIN : S_REQ;
                    S_WAIT:  state_next = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
                    S_DRAIN: state_next = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
                    default: state_next = S_REQ;
                endcase
            end
        end else begin
            case (state)
                S_REQ:   if (bus.imem_req_ready) state_next = S_WAIT;
                S_WAIT:  if (bus.imem_rsp_valid) begin
                    push       = 1'b1;
                    state_next = (count_after_push < DEPTH_C) ? S_REQ : S_FULL;
                end
                S_DRAIN: if (bus.imem_rsp_valid) state_next = S_REQ;
                S_FULL:  if (count < DEPTH_C) state_next = S_REQ;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        bus.imem_req_valid = resetl && (state == S_REQ);
        bus.imem_req_addr  = fetch_pc;
        head_inst          = head_valid ? buf_inst[rd_ptr] : '0;
        head_pc            = head_valid ? buf_pc[rd_ptr] : '0;
        bus.if_valid       = head_valid;
        bus.if_inst        = head_inst;
        bus.if_pc          = head_pc;
        CurrentPC          = head_pc;
        state_dbg          = state;
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            fetch_pc <= startPC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (load_pc)   fetch_pc <= target_pc;
            else if (push) fetch_pc <= fetch_pc + PC_WIDTH'(4);
            // Flush wins over a same-cycle pop.
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            buf_inst[wr_ptr] <= bus.imem_rsp_data;
            buf_pc[wr_ptr]   <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic, with a
// memory responder and a scoreboard holding the expected decode stream.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
    localparam int PC_W   = 64;
    localparam int INST_W = 32;
    localparam int DEPTH  = 2;
    localparam logic [2:0] ST_REQ  = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_FULL = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;

    logic            clk = 1'b0;
    logic            resetl = 1'b1;
    logic            redirect = 1'b0;
    logic [PC_W-1:0] start_pc = 64'h400;
    logic [PC_W-1:0] next_pc = '0;
    logic [PC_W-1:0] current_pc;
    logic            misalign;
    logic [2:0]      state_dbg;

    instruction_fetch_unit_if #(.PC_WIDTH(PC_W), .INST_WIDTH(INST_W)) bus ();

    instruction_fetch_unit #(.PC_WIDTH(PC_W), .INST_WIDTH(INST_W), .BUF_DEPTH(DEPTH)) dut (
        .CLK(clk), .resetl(resetl), .startPC(start_pc), .NextPC(next_pc),
        .redirect(redirect), .CurrentPC(current_pc), .misalign(misalign),
        .state_dbg(state_dbg), .bus(bus)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    logic [INST_W+PC_W-1:0] exp_q[$];
    logic [PC_W-1:0]        model_next_pc;
    logic [PC_W-1:0]        exp_req_addr;
    int n_cmp = 0, n_err = 0, n_deliv = 0;

    function automatic logic [INST_W-1:0] mem_word(input logic [PC_W-1:0] pc);
        return (pc[31:0] * 32'h9E37_79B1) ^ pc[63:32] ^ 32'h1357_2468;
    endfunction

    function automatic logic [PC_W-1:0] aligned(input logic [PC_W-1:0] pc);
`ifdef FETCH_MISALIGN_TRAP_EN
        return pc;
`else
        return {pc[PC_W-1:2], 2'b00};
`endif
    endfunction

    task automatic check(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_top_up();
        while (exp_q.size() < 32) begin
            exp_q.push_back({mem_word(model_next_pc), model_next_pc});
            model_next_pc += 64'd4;
        end
    endtask

    task automatic model_restart(input logic [PC_W-1:0] pc);
        exp_q.delete();
        model_next_pc = pc;
        model_top_up();
    endtask

    // ---------------- memory responder ----------------
    logic            mem_rand_ready = 1'b0;
    int              mem_min_dly = 0, mem_max_dly = 0;
    logic            mem_fire, mem_pend = 1'b0;
    logic [PC_W-1:0] mem_fire_addr, mem_pend_addr;
    int              mem_dly = 0;

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            mem_fire      = bus.imem_req_valid && bus.imem_req_ready;
            mem_fire_addr = bus.imem_req_addr;
            @(posedge clk);
            #1;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom();
            if (!resetl) begin
                mem_pend = 1'b0;
            end else begin
                if (mem_fire) begin
                    mem_pend      = 1'b1;
                    mem_pend_addr = mem_fire_addr;
                    mem_dly       = $urandom_range(mem_min_dly, mem_max_dly);
                end
                if (mem_pend) begin
                    if (mem_dly == 0) begin
                        bus.imem_rsp_valid = 1'b1;
                        bus.imem_rsp_data  = mem_word(mem_pend_addr);
                        mem_pend           = 1'b0;
                    end else begin
                        mem_dly--;
                    end
                end
            end
            bus.imem_req_ready = mem_rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- monitor ----------------
    logic prev_redirect = 1'b0;
    logic [INST_W+PC_W-1:0] mon_e;
    initial begin
        exp_req_addr = start_pc;
        forever begin
            @(negedge clk);
            if (!resetl) begin
                exp_req_addr  = start_pc;
                prev_redirect = 1'b0;
            end else begin
                if (prev_redirect) check("if_valid_after_redirect", {63'd0, bus.if_valid}, 64'd0);
                if (bus.if_valid && bus.if_ready && !redirect) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL deliver: got pc %0h expected nothing", bus.if_pc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("if_pc", bus.if_pc, mon_e[PC_W-1:0]);
                        check("if_inst", {32'd0, bus.if_inst}, {32'd0, mon_e[INST_W+PC_W-1:PC_W]});
                        check("CurrentPC", current_pc, mon_e[PC_W-1:0]);
                        n_deliv++;
                    end
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    check("req_addr", bus.imem_req_addr, exp_req_addr);
                    exp_req_addr += 64'd4;
                end
                if (redirect) exp_req_addr = aligned(next_pc);
                prev_redirect = redirect;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
        model_top_up();
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        check("rst_if_valid", {63'd0, bus.if_valid}, 64'd0);
        check("rst_if_pc", bus.if_pc, 64'd0);
        check("rst_if_inst", {32'd0, bus.if_inst}, 64'd0);
        check("rst_CurrentPC", current_pc, 64'd0);
        check("rst_misalign", {63'd0, misalign}, 64'd0);
        check("rst_state", {61'd0, state_dbg}, {61'd0, ST_REQ});
    endtask

    task automatic do_reset();
        resetl = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        tick();
        model_restart(start_pc);
        resetl = 1'b1;
    endtask

    task automatic issue_redirect(input logic [PC_W-1:0] target);
        next_pc      = target;
        redirect     = 1'b1;
        bus.if_ready = 1'b0;
        model_restart(aligned(target));
        tick();
        redirect = 1'b0;
        next_pc  = {32'd0, $urandom()};
    endtask

    task automatic wait_state(input logic [2:0] st, input logic use_rsp, input logic rsp, input string name);
        int i;
        for (i = 0; i < 60; i++) begin
            if (state_dbg == st && (!use_rsp || bus.imem_rsp_valid == rsp)) break;
            tick();
        end
        n_cmp++;
        if (i == 60) begin
            n_err++;
            $display("FAIL %s: got timeout expected state %0d", name, st);
        end
    endtask

    // ---------------- main sequence ----------------
    logic [PC_W-1:0] tgt;
    int              start_deliv, req_seen;
    initial begin
        bus.if_ready = 1'b0;
        #1;
        resetl = 1'b0;
        #2;
        check_reset_outputs();
        tick();
        tick();
        model_restart(start_pc);

        // Straight-line fetch from 0x400 with a one-cycle memory.
        bus.if_ready = 1'b1;
        resetl = 1'b1;
        repeat (12) tick();
        check("seq_deliveries_ge3", {63'd0, n_deliv >= 3}, 64'd1);

        // Decode stalled: buffer fills, fetch pauses, then resumes in order.
        bus.if_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        check("full_state", {61'd0, state_dbg}, {61'd0, ST_FULL});
        check("full_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        check("full_if_valid", {63'd0, bus.if_valid}, 64'd1);
        check("full_head_pc", bus.if_pc, 64'h400);
        bus.if_ready = 1'b1;
        repeat (12) tick();

        // Redirect while waiting on a slow response.
        mem_min_dly = 2;
        mem_max_dly = 2;
        wait_state(ST_WAIT, 1'b1, 1'b0, "wait_no_rsp");
        issue_redirect(64'h1000);
        bus.if_ready = 1'b1;
        start_deliv = n_deliv;
        repeat (20) tick();
        check("redir_wait_delivered", {63'd0, n_deliv > start_deliv}, 64'd1);

        // Redirect landing on the response pulse.
        mem_min_dly = 0;
        mem_max_dly = 0;
        wait_state(ST_WAIT, 1'b1, 1'b1, "wait_with_rsp");
        issue_redirect(64'h2000);
        bus.if_ready = 1'b1;
        req_seen = 0;
        for (int i = 0; i < 10 && req_seen == 0; i++) begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                check("redir_rsp_next_req", bus.imem_req_addr, 64'h2000);
                req_seen = 1;
            end
            tick();
        end
        check("redir_rsp_req_seen", {32'd0, req_seen}, 64'd1);
        repeat (6) tick();

        // Reset pulse during an outstanding fetch.
        mem_min_dly = 2;
        mem_max_dly = 2;
        wait_state(ST_WAIT, 1'b0, 1'b0, "wait_before_reset");
        do_reset();
        repeat (16) tick();
        mem_min_dly = 0;
        mem_max_dly = 0;

        // Misaligned redirect target.
        issue_redirect(64'h1002);
        bus.if_ready = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_misalign", {63'd0, misalign}, 64'd1);
        check("trap_state", {61'd0, state_dbg}, {61'd0, ST_HALT});
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.imem_req_valid) req_seen++;
            tick();
        end
        check("trap_no_requests", {32'd0, req_seen}, 64'd0);
        check("trap_sticky", {63'd0, misalign}, 64'd1);
        do_reset();
`else
        check("no_trap_misalign", {63'd0, misalign}, 64'd0);
        repeat (12) tick();
        check("no_trap_head_pc_aligned", {62'd0, current_pc[1:0]}, 64'd0);
`endif

        // Random traffic: stalls on both sides, redirects, occasional reset.
        mem_rand_ready = 1'b1;
        mem_min_dly    = 0;
        mem_max_dly    = 2;
        start_deliv    = n_deliv;
        for (int c = 0; c < 3000; c++) begin
            bus.if_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                start_pc = {32'd0, $urandom()} & ~64'h3;
                do_reset();
            end else if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF8;
                else                           tgt = {32'd0, $urandom()};
`ifdef FETCH_MISALIGN_TRAP_EN
                tgt[1:0] = 2'b00;
`endif
                issue_redirect(tgt);
            end else begin
                tick();
            end
        end
        check("random_deliveries", {63'd0, (n_deliv - start_deliv) > 200}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 64, SHALL set the width of all program-counter ports.
REQ-002 Parameter INST_WIDTH, default 32, SHALL set the instruction word width.
REQ-003 Parameter BUF_DEPTH, default 2, SHALL set the fetch-buffer entry count (power of two, >=2).
REQ-004 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 resetl  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 startPC  in  PC_WIDTH  SHALL be the PC loaded into the fetch pointer while resetl=0.
REQ-007 NextPC  in  PC_WIDTH  SHALL be the redirect target from the next-PC logic.
REQ-008 redirect  in  1  SHALL, when 1, replace the fetch pointer with NextPC (taken branch).
REQ-009 imem_req_valid  out  1; imem_req_addr  out  PC_WIDTH; imem_req_ready  in  1 SHALL form the instruction-memory request handshake.
REQ-010 imem_rsp_valid  in  1; imem_rsp_data  in  INST_WIDTH SHALL carry the one-cycle response pulse.
REQ-011 if_valid  out  1; if_inst  out  INST_WIDTH; if_pc  out  PC_WIDTH; if_ready  in  1 SHALL form the decode-side handshake.
REQ-012 CurrentPC  out  PC_WIDTH SHALL equal if_pc, feeding the next-PC logic.
REQ-013 misalign  out  1 SHALL flag a trapped misaligned redirect (see Configuration).

Function
REQ-014 States SHALL be REQ, WAIT, DRAIN, FULL, HALT; at most one memory request outstanding.
REQ-015 REQ: imem_req_valid=1, imem_req_addr=fetch_pc; on imem_req_ready -> WAIT.
REQ-016 WAIT: on imem_rsp_valid, push {imem_rsp_data, fetch_pc} into the buffer, fetch_pc += 4 (mod 2^PC_WIDTH), then -> REQ if post-push count < BUF_DEPTH, else -> FULL.
REQ-017 FULL: imem_req_valid=0; -> REQ on the cycle after the buffer count drops below BUF_DEPTH.
REQ-018 Buffer SHALL be FIFO; if_valid=1 when count>0, head presented combinationally; pop when if_valid & if_ready.
REQ-019 Simultaneous push and pop SHALL keep count unchanged; pointers wrap modulo BUF_DEPTH.
REQ-020 Redirect in REQ (no handshake), FULL: flush buffer, fetch_pc<=NextPC, -> REQ next cycle.
REQ-021 Redirect in REQ with imem_req_ready=1, or in WAIT without imem_rsp_valid: flush, fetch_pc<=NextPC, -> DRAIN.
REQ-022 Redirect in WAIT with imem_rsp_valid=1: response discarded, flush, fetch_pc<=NextPC, -> REQ.
REQ-023 DRAIN: imem_req_valid=0; next imem_rsp_valid discarded, -> REQ; redirect in DRAIN updates fetch_pc, remains DRAIN unless the response arrives the same cycle.
REQ-024 Flush SHALL override a same-cycle pop; if_valid=0 the cycle after any redirect.
REQ-025 Latency: first if_valid no earlier than 1 cycle after the response pulse (registered buffer).

Reset
REQ-026 While resetl=0: state=REQ, fetch_pc=startPC, buffer empty, if_valid=0, imem_req_valid=0, misalign=0, if_pc=CurrentPC=0, if_inst=0.
REQ-027 Reset asserted mid-transaction SHALL abandon outstanding requests; the first response after reset release SHALL belong only to a request issued after release.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with NextPC[1:0]!=0 SHALL set misalign=1 (sticky), flush, -> HALT; HALT issues no requests and ignores redirect until reset.
REQ-029 Macro undefined: NextPC[1:0] SHALL be forced to 00 on load; misalign tied 0; HALT unreachable.

Verification
REQ-030 startPC=0x400, ready=1, 1-cycle memory, if_ready=1 -> if_pc sequence 0x400,0x404,0x408, inst matches memory.
REQ-031 if_ready=0 after reset, BUF_DEPTH=2 -> two entries (0x400,0x404) buffered, state FULL, imem_req_valid=0; if_ready=1 -> 0x400 delivered first, fetch resumes at 0x408.
REQ-032 Redirect NextPC=0x1000 while in WAIT -> stale response discarded, next if_pc=0x1000, no 0x40x value appears after redirect.
REQ-033 Redirect NextPC=0x2000 coincident with imem_rsp_valid -> response dropped, next request addr=0x2000.
REQ-034 resetl pulsed low while in WAIT -> all outputs at reset values immediately, first request addr=startPC.
REQ-035 Redirect NextPC=0x1002: with FETCH_MISALIGN_TRAP_EN -> misalign=1, no further requests; without -> request addr=0x1000.
